// File: rtl/cram_wr_arb.sv
// CRAM write arbiter: CPU writes always win, DMA bursts fill the palette otherwise.
// Build option: CRAM_DMA_BLANK_ONLY_EN restricts DMA beats to blanking periods.
module cram_wr_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic        dma_start,
  input  logic        dma_abort,
  input  logic [7:0]  dma_saddr,
  input  logic [7:0]  dma_len,
  input  logic [15:0] dma_data,
  input  logic        dma_valid,
  output logic        dma_ready,
  output logic        dma_busy,
  output logic        dma_done,
  input  logic        blank,
  output logic        cram_we_out,
  output logic [7:0]  cram_addr_out,
  output logic [15:0] cram_data_out
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nx;
  logic [7:0]  cur_addr;
  logic [8:0]  remaining;
  logic        gate;
  logic        beat;
  logic        last;

`ifdef CRAM_DMA_BLANK_ONLY_EN
  assign gate = blank;
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign gate = 1'b1;
`endif

  assign dma_busy  = (state == RUN);
  assign dma_ready = dma_busy & ~cpu_we & ~dma_abort & gate;
  assign beat      = dma_valid & dma_ready;
  assign last      = (remaining == 9'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (dma_start) state_nx = RUN;
      RUN: begin
        if (dma_abort)         state_nx = IDLE;
        else if (beat && last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= 8'd0;
      remaining <= 9'd0;
    end else if (state == IDLE) begin
      if (dma_start) begin
        cur_addr  <= dma_saddr;
        remaining <= (dma_len == 8'd0) ? 9'd256 : {1'b0, dma_len};
      end
    end else if (beat) begin
      cur_addr  <= cur_addr + 8'd1;
      remaining <= remaining - 9'd1;
    end
  end

  // Data/address hold their last value when no write is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cram_we_out   <= 1'b0;
      cram_addr_out <= 8'd0;
      cram_data_out <= 16'd0;
      dma_done      <= 1'b0;
    end else begin
      cram_we_out <= cpu_we | beat;
      dma_done    <= beat & last;
      if (cpu_we) begin
        cram_addr_out <= cpu_addr;
        cram_data_out <= cpu_data;
      end else if (beat) begin
        cram_addr_out <= cur_addr;
        cram_data_out <= dma_data;
      end
    end
  end

endmodule

// File: tb/tb_cram_wr_arb.sv
// Scoreboard bench for cram_wr_arb.
// A bench-side model predicts dma_ready and every palette write.
module tb_cram_wr_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_addr = 8'd0;
  logic [15:0] cpu_data = 16'd0;
  logic        dma_start = 1'b0;
  logic        dma_abort = 1'b0;
  logic [7:0]  dma_saddr = 8'd0;
  logic [7:0]  dma_len = 8'd0;
  logic [15:0] dma_data = 16'd0;
  logic        dma_valid = 1'b0;
  logic        dma_ready;
  logic        dma_busy;
  logic        dma_done;
  logic        blank = 1'b0;
  logic        cram_we_out;
  logic [7:0]  cram_addr_out;
  logic [15:0] cram_data_out;

  cram_wr_arb dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .dma_start(dma_start), .dma_abort(dma_abort),
    .dma_saddr(dma_saddr), .dma_len(dma_len),
    .dma_data(dma_data), .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_busy(dma_busy), .dma_done(dma_done), .blank(blank),
    .cram_we_out(cram_we_out), .cram_addr_out(cram_addr_out),
    .cram_data_out(cram_data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
    logic        done;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_busy = 1'b0;
  logic [7:0]  m_addr = 8'd0;
  int          m_rem = 0;
  logic [7:0]  last_a = 8'd0;
  logic [15:0] last_d = 16'd0;
  int          wr_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call at posedge+1; returns at next posedge+1
  task automatic step();
    logic g, rdy, bt;
    exp_t e;
`ifdef CRAM_DMA_BLANK_ONLY_EN
    g = blank;
`else
    g = 1'b1;
`endif
    #2;
    rdy = m_busy & ~cpu_we & ~dma_abort & g;
    bt  = rdy & dma_valid;
    chk("ready", {31'd0, dma_ready}, {31'd0, rdy});
    if (cpu_we) q.push_back('{cpu_addr, cpu_data, 1'b0});
    else if (bt) q.push_back('{m_addr, dma_data, m_rem == 1});
    @(posedge clk);
    #1;
    if (m_busy) begin
      if (dma_abort) m_busy = 1'b0;
      else if (bt) begin
        m_addr = m_addr + 8'd1;
        m_rem--;
        if (m_rem == 0) m_busy = 1'b0;
      end
    end else if (dma_start) begin
      m_busy = 1'b1;
      m_addr = dma_saddr;
      m_rem  = (dma_len == 8'd0) ? 256 : int'(dma_len);
    end
    if (cram_we_out) wr_cnt++;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("we", {31'd0, cram_we_out}, 32'd1);
      chk("addr", {24'd0, cram_addr_out}, {24'd0, e.a});
      chk("data", {16'd0, cram_data_out}, {16'd0, e.d});
      chk("done", {31'd0, dma_done}, {31'd0, e.done});
      last_a = e.a;
      last_d = e.d;
    end else begin
      chk("we_idle", {31'd0, cram_we_out}, 32'd0);
      chk("done_idle", {31'd0, dma_done}, 32'd0);
      chk("addr_hold", {24'd0, cram_addr_out}, {24'd0, last_a});
      chk("data_hold", {16'd0, cram_data_out}, {16'd0, last_d});
    end
    chk("busy", {31'd0, dma_busy}, {31'd0, m_busy});
    cpu_we = 1'b0;
    dma_start = 1'b0;
    dma_abort = 1'b0;
    dma_data = dma_data + 16'h0101;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_we"}, {31'd0, cram_we_out}, 32'd0);
    chk({tag, "_addr"}, {24'd0, cram_addr_out}, 32'd0);
    chk({tag, "_data"}, {16'd0, cram_data_out}, 32'd0);
    chk({tag, "_done"}, {31'd0, dma_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, dma_busy}, 32'd0);
    chk({tag, "_ready"}, {31'd0, dma_ready}, 32'd0);
  endtask

  task automatic start(input logic [7:0] sa, input logic [7:0] ln);
    dma_saddr = sa;
    dma_len = ln;
    dma_start = 1'b1;
    step();
  endtask

  initial begin
    dma_valid = 1'b1;
    blank = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_n = 1'b1;

    // CPU write while idle
    cpu_we = 1'b1; cpu_addr = 8'h12; cpu_data = 16'h7C00;
    step();
    step();

    // Burst wrapping 0xFE..0x00; a restart attempt mid-burst is ignored
    dma_data = 16'h1000;
    start(8'hFE, 8'd3);
    step();
    dma_start = 1'b1; dma_saddr = 8'h55; dma_len = 8'd9;
    step();
    step();
    step();
    chk("burst_busy_after", {31'd0, dma_busy}, 32'd0);

    // CPU/DMA collision, plus a stall with valid low
    start(8'h10, 8'd3);
    cpu_we = 1'b1; cpu_addr = 8'hA5; cpu_data = 16'h5A5A;
    step();
    dma_valid = 1'b0;
    step();
    step();
    dma_valid = 1'b1;
    for (int i = 0; i < 6 && m_busy; i++) step();

    // len 0 means 256 beats from 0x40 with sporadic stalls
    wr_cnt = 0;
    start(8'h40, 8'd0);
    for (int i = 0; i < 400 && m_busy; i++) begin
      dma_valid = (i % 37) != 5;
      step();
    end
    dma_valid = 1'b1;
    chk("len0_writes", wr_cnt, 32'd256);
    chk("len0_idle", {31'd0, dma_busy}, 32'd0);

    // Abort after 2 of 5 beats, then valid stays high with no writes
    start(8'h80, 8'd5);
    step();
    step();
    dma_abort = 1'b1;
    step();
    repeat (3) step();
    dma_abort = 1'b1;
    step();

    // Blank low: gated only when the blank-only build is selected
    start(8'h20, 8'd4);
    blank = 1'b0;
    step();
    step();
    blank = 1'b1;
    for (int i = 0; i < 8 && m_busy; i++) step();

    // Asynchronous reset mid-burst
    start(8'hC0, 8'd6);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    @(posedge clk);
    #1;
    chk_reset_outs("hold_rst");
    rst_n = 1'b1;
    q.delete();
    m_busy = 1'b0;
    last_a = 8'd0;
    last_d = 16'd0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cram_wr_arb.md
CRAM_WR_ARB -- requirements
Module: cram_wr_arb

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset, with ports listed clock and reset first:
- clk  in  1  system clock (28 MHz domain)
- rst_n  in  1  asynchronous active-low reset
REQ-002 CPU write-port signals SHALL be:
- cpu_we  in  1  single-cycle CRAM write strobe
- cpu_addr  in  8  palette index
- cpu_data  in  16  colour word
REQ-003 DMA control signals SHALL be:
- dma_start  in  1  start-burst pulse
- dma_abort  in  1  cancel-burst pulse
- dma_saddr  in  8  burst start index
- dma_len  in  8  burst length in words; 0 means 256
REQ-004 DMA data handshake signals SHALL be:
- dma_data  in  16  burst word
- dma_valid  in  1  burst word present
- dma_ready  out  1  burst word accepted this cycle
REQ-005 DMA status signals SHALL be:
- dma_busy  out  1  burst in progress
- dma_done  out  1  one-cycle completion pulse
REQ-006 Blanking input SHALL be: blank  in  1  active-video blanking (1 = blanked).
REQ-007 Write-port outputs driving the palette RAM SHALL be:
- cram_we_out  out  1  write enable
- cram_addr_out  out  8  write address
- cram_data_out  out  16  write data

Function
REQ-008 The FSM SHALL have states IDLE and RUN, and dma_busy SHALL equal (state==RUN).
REQ-009 In IDLE, dma_start SHALL latch dma_saddr into cur_addr and dma_len into remaining (0 loaded as 256, 9-bit counter), and the FSM SHALL enter RUN on the next edge.
REQ-010 In RUN, dma_start SHALL be ignored.
REQ-011 dma_ready SHALL be combinational: (state==RUN) & !cpu_we & !dma_abort & gate, where gate is defined in REQ-020/021.
REQ-012 A CPU write SHALL always win arbitration: cpu_we at cycle N SHALL produce cram_we_out=1 with cpu_addr/cpu_data at cycle N+1 (latency 1, registered outputs).
REQ-013 A DMA beat SHALL be the condition dma_valid & dma_ready at cycle N, and SHALL produce cram_we_out=1 with cur_addr/dma_data at cycle N+1.
REQ-014 On each DMA beat, cur_addr SHALL increment modulo 256 (0xFF wraps to 0x00) and remaining SHALL decrement.
REQ-015 A beat with remaining==1 SHALL return the FSM to IDLE, and dma_done SHALL be 1 at cycle N+1 together with the last write.
REQ-016 dma_abort in RUN SHALL force IDLE on the next edge, SHALL accept no beat that cycle, and SHALL produce no dma_done pulse; dma_abort in IDLE SHALL have no effect.
REQ-017 When neither a CPU write nor a DMA beat occurs, cram_we_out SHALL be 0 and cram_addr_out/cram_data_out SHALL hold their last values.
REQ-018 A DMA stall (dma_valid=0, or ready blocked) SHALL have no timeout; state, cur_addr and remaining SHALL be held.

Reset
REQ-019 Asserting rst_n=0 SHALL, asynchronously and at any time including mid-burst:
- force state=IDLE
- clear cram_we_out, cram_addr_out, cram_data_out, dma_done, cur_addr and remaining to 0
- leave dma_ready=0 and dma_busy=0 for as long as reset is held
A burst interrupted by reset SHALL be lost, with no dma_done.

Configuration
REQ-020 With macro CRAM_DMA_BLANK_ONLY_EN defined, gate SHALL equal blank, so DMA beats are accepted only during blanking (no mid-line palette tearing).
REQ-021 With CRAM_DMA_BLANK_ONLY_EN undefined, gate SHALL be 1 and blank SHALL be unused; CPU writes SHALL never be gated in either build.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- CPU write, idle: cpu_we=1, addr 0x12, data 0x7C00 at cycle N -> cram_we_out=1, addr 0x12, data 0x7C00 at N+1; cram_we_out=0 at N+2.
- Burst: dma_saddr=0xFE, dma_len=3, dma_valid held 1 -> writes to 0xFE, 0xFF, 0x00 on consecutive cycles; dma_done=1 with the 0x00 write; dma_busy=0 afterwards.
- Collision: cpu_we=1 in the same cycle as dma_valid in RUN -> dma_ready=0 that cycle; CPU write issued; DMA beat issued one cycle later; no words lost.
- dma_len=0: 256 beats, addresses 0x40..0x3F wrapped -> exactly 256 writes, one dma_done.
- Abort and reset: dma_abort after 2 of 5 beats -> IDLE, no dma_done, no further writes; rst_n=0 mid-burst -> all outputs 0 immediately.
- Blank gating, with CRAM_DMA_BLANK_ONLY_EN defined: blank=0 -> dma_ready=0 with valid held; blank=1 -> beats resume.
